// File: rtl/phy_pkg.sv
// Shared definitions for the PHY receive path: alignment symbol, symbol width and
// the word-aligner state encoding.
package phy_pkg;

  localparam int unsigned BYTE_W_DEFAULT   = 8;
  localparam logic [7:0]  COM_CHAR_DEFAULT = 8'hBC;

  typedef enum logic [1:0] {
    StHunt,
    StAlign,
    StLocked
  } align_state_e;

endpackage

// File: rtl/phy_sync_fifo.sv
// Single-clock FIFO with registered head word. A push while full is taken only when a
// pop frees a slot on the same edge; otherwise it is ignored.
module phy_sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [Width-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = head_q;

  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q + PtrW'(do_push);
    rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
    count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
    // The slot becoming head may be the one written on this very edge.
    if (do_push && (wr_ptr_q == rd_ptr_d)) begin
      head_d = data_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/phy_byte_word_aligner.sv
// Hunts for COM in a byte stream, locks word alignment after a run of COM-led words and
// then packs bytes MSB-first into words delivered through a ready/valid FIFO.
module phy_byte_word_aligner
  import phy_pkg::*;
#(
  parameter int unsigned       BYTE_W         = BYTE_W_DEFAULT,
  parameter int unsigned       BYTES_PER_WORD = 4,
  parameter logic [BYTE_W-1:0] COM_CHAR       = BYTE_W'(COM_CHAR_DEFAULT),
  parameter int unsigned       LOCK_COUNT     = 4,
  parameter int unsigned       FIFO_DEPTH     = 4
) (
  input  logic                             clk_32f,
  input  logic                             reset,
  input  logic [BYTE_W-1:0]                in_data,
  input  logic                             in_valid,
  output logic [BYTE_W*BYTES_PER_WORD-1:0] out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             locked,
  output logic                             sync_err,
  output logic                             overflow
);

  localparam int unsigned WordW = BYTE_W * BYTES_PER_WORD;
  localparam int unsigned LaneW = $clog2(BYTES_PER_WORD);
  localparam int unsigned CntW  = $clog2(LOCK_COUNT + 1);

  localparam logic [LaneW-1:0] LastLane = LaneW'(BYTES_PER_WORD - 1);
  localparam logic [CntW-1:0]  LockCnt  = CntW'(LOCK_COUNT);

  align_state_e     state_q, state_d;
  logic [LaneW-1:0] lane_q, lane_d;
  logic [CntW-1:0]  align_cnt_q, align_cnt_d;
  logic [WordW-1:0] word_q, word_d;
  logic [WordW-1:0] placed, com_word;
  logic             sync_err_q, sync_err_d;
  logic             overflow_q, overflow_d;
  logic             is_com, push, pop, fifo_full, fifo_empty;

  always_comb begin
    is_com = (in_data == COM_CHAR);

    placed = word_q;
    for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
      if (lane_q == LaneW'(k)) begin
        placed[WordW-1-k*BYTE_W -: BYTE_W] = in_data;
      end
    end
    com_word = word_q;
    com_word[WordW-1 -: BYTE_W] = COM_CHAR;

    state_d     = state_q;
    lane_d      = lane_q;
    align_cnt_d = align_cnt_q;
    word_d      = word_q;
    push        = 1'b0;
    sync_err_d  = 1'b0;

    if (in_valid) begin
      case (state_q)
        StHunt: begin
          if (is_com) begin
            word_d      = com_word;
            lane_d      = LaneW'(1);
            align_cnt_d = '0;
            state_d     = StAlign;
          end
        end

        StAlign: begin
          if (lane_q == '0) begin
            if (is_com) begin
              word_d = com_word;
              lane_d = LaneW'(1);
            end else begin
              state_d = StHunt;
            end
          end else if (is_com) begin
            word_d      = com_word;
            lane_d      = LaneW'(1);
            align_cnt_d = '0;
          end else begin
            word_d = placed;
            if (lane_q == LastLane) begin
              lane_d      = '0;
              align_cnt_d = align_cnt_q + CntW'(1);
              if (align_cnt_d == LockCnt) begin
                state_d = StLocked;
                push    = 1'b1;
              end
            end else begin
              lane_d = lane_q + LaneW'(1);
            end
          end
        end

        StLocked: begin
          if (is_com && (lane_q != '0)) begin
            // Misplaced COM: drop the partial word and realign on this COM.
            sync_err_d  = 1'b1;
            state_d     = StAlign;
            word_d      = com_word;
            lane_d      = LaneW'(1);
            align_cnt_d = '0;
          end else begin
            word_d = placed;
            if (lane_q == LastLane) begin
              lane_d = '0;
              push   = 1'b1;
            end else begin
              lane_d = lane_q + LaneW'(1);
            end
          end
        end

        default: state_d = StHunt;
      endcase
    end

    pop        = out_valid && out_ready;
    overflow_d = push && fifo_full && !pop;
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state_q     <= StHunt;
      lane_q      <= '0;
      align_cnt_q <= '0;
      word_q      <= '0;
      sync_err_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      align_cnt_q <= align_cnt_d;
      word_q      <= word_d;
      sync_err_q  <= sync_err_d;
      overflow_q  <= overflow_d;
    end
  end

  phy_sync_fifo #(
    .Width (WordW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_32f (clk_32f),
    .reset   (reset),
    .push_i  (push),
    .data_i  (placed),
    .pop_i   (pop),
    .head_o  (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign locked    = (state_q == StLocked);
  assign sync_err  = sync_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_phy_byte_word_aligner.sv
// Randomised scoreboard bench for phy_byte_word_aligner with a byte-queue reference model,
// plus a small directed check of a 2-byte, single-word-lock configuration.
module tb_phy_byte_word_aligner;

  localparam int unsigned BPW   = 4;
  localparam int unsigned LOCK  = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  COM   = 8'hBC;

  typedef enum int {MHunt, MAlign, MLocked} mmode_e;
  typedef struct {
    int cyc;
    bit sync;
    bit ovf;
    bit lock;
    bit rst;
  } flag_t;

  logic        clk_32f = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        locked, sync_err, overflow;

  logic [7:0]  in_data2;
  logic        in_valid2;
  logic [15:0] out_data2;
  logic        out_valid2;
  logic        out_ready2;
  logic        locked2, sync_err2, overflow2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] exp_q[$];
  flag_t       flag_q[$];

  mmode_e     mode;
  logic [7:0] cur[$];
  int         cnt;
  int         occ;

  always #5 clk_32f = ~clk_32f;
  always @(posedge clk_32f) cyc <= cyc + 1;

  phy_byte_word_aligner dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .locked    (locked),
    .sync_err  (sync_err),
    .overflow  (overflow)
  );

  phy_byte_word_aligner #(
    .BYTES_PER_WORD (2),
    .LOCK_COUNT     (1)
  ) dut2 (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .in_data   (in_data2),
    .in_valid  (in_valid2),
    .out_data  (out_data2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .locked    (locked2),
    .sync_err  (sync_err2),
    .overflow  (overflow2)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Reference model: one accepted byte; words are built by shifting bytes in, MSB first.
  task automatic model_byte(input logic [7:0] b, output bit emit, output logic [31:0] w,
                            output bit se);
    emit = 1'b0;
    w    = '0;
    se   = 1'b0;
    case (mode)
      MHunt: begin
        if (b == COM) begin
          cur.delete();
          cur.push_back(b);
          cnt  = 0;
          mode = MAlign;
        end
      end
      MAlign: begin
        if (cur.size() == 0) begin
          if (b == COM) cur.push_back(b);
          else mode = MHunt;
        end else if (b == COM) begin
          cur.delete();
          cur.push_back(b);
          cnt = 0;
        end else begin
          cur.push_back(b);
          if (cur.size() == BPW) begin
            foreach (cur[i]) w = (w << 8) | 32'(cur[i]);
            cur.delete();
            cnt++;
            if (cnt == LOCK) begin
              mode = MLocked;
              emit = 1'b1;
            end
          end
        end
      end
      default: begin
        if (b == COM && cur.size() != 0) begin
          se   = 1'b1;
          mode = MAlign;
          cur.delete();
          cur.push_back(b);
          cnt  = 0;
        end else begin
          cur.push_back(b);
          if (cur.size() == BPW) begin
            foreach (cur[i]) w = (w << 8) | 32'(cur[i]);
            cur.delete();
            emit = 1'b1;
          end
        end
      end
    endcase
  endtask

  // Called just after a rising edge; presents inputs for the next edge and predicts it.
  task automatic drive(input bit v, input logic [7:0] d, input bit rdy);
    flag_t       f;
    bit          pop, emit, se;
    logic [31:0] w;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    pop  = (occ > 0) && rdy;
    emit = 1'b0;
    se   = 1'b0;
    w    = '0;
    if (v) model_byte(d, emit, w, se);
    f.ovf = 1'b0;
    if (emit) begin
      if (occ < DEPTH || pop) begin
        exp_q.push_back(w);
        occ++;
      end else begin
        f.ovf = 1'b1;
      end
    end
    if (pop) occ--;
    f.cyc  = cyc + 1;
    f.sync = se;
    f.lock = (mode == MLocked);
    f.rst  = 1'b0;
    flag_q.push_back(f);
    @(posedge clk_32f);
    #1;
  endtask

  task automatic do_reset(input bit v, input logic [7:0] d);
    flag_t f;
    reset     = 1'b0;
    in_valid  = v;
    in_data   = d;
    out_ready = 1'b0;
    mode = MHunt;
    cur.delete();
    cnt = 0;
    occ = 0;
    exp_q.delete();
    flag_q.delete();
    f.cyc  = cyc + 1;
    f.sync = 1'b0;
    f.ovf  = 1'b0;
    f.lock = 1'b0;
    f.rst  = 1'b1;
    flag_q.push_back(f);
    @(posedge clk_32f);
    #1;
    reset = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit rdy);
    for (int k = 0; k < 4; k++) drive(1'b1, w[31-8*k -: 8], rdy);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 8'h00, 1'b1);
  endtask

  // Monitor: handshakes pop the scoreboard; per-cycle flag predictions are matched by edge.
  initial begin
    flag_t       f;
    logic [31:0] w;
    forever begin
      @(negedge clk_32f);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word_unexpected: got %0h required no word", out_data);
        end else begin
          w = exp_q.pop_front();
          if (out_data !== w) begin
            errors++;
            $display("FAIL word: got %0h required %0h", out_data, w);
          end
        end
      end
      while (flag_q.size() > 0 && flag_q[0].cyc < cyc) void'(flag_q.pop_front());
      if (flag_q.size() > 0 && flag_q[0].cyc == cyc) begin
        f = flag_q.pop_front();
        check("locked", 64'(locked), 64'(f.lock));
        check("sync_err", 64'(sync_err), 64'(f.sync));
        check("overflow", 64'(overflow), 64'(f.ovf));
        if (f.rst) begin
          check("rst_out_valid", 64'(out_valid), 64'd0);
          check("rst_out_data", 64'(out_data), 64'd0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         rmode;
    int         pos;
    bit         v, rdy;
    logic [7:0] d;
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    in_valid2  = 1'b0;
    in_data2   = '0;
    out_ready2 = 1'b1;
    mode = MHunt;
    cnt  = 0;
    occ  = 0;
    repeat (2) @(posedge clk_32f);
    #1;
    do_reset(1'b0, 8'h00);

    // Lock acquisition: leading junk discarded, fourth COM-led word is the first pushed.
    drive(1'b1, 8'h00, 1'b1);
    drive(1'b1, 8'h11, 1'b1);
    for (int i = 0; i < 3; i++) send_word(32'hBC010203, 1'b1);
    check("pre_lock", 64'(locked), 64'd0);
    send_word(32'hBC010203, 1'b1);
    check("lock_rise", 64'(locked), 64'd1);
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_word", 64'(out_data), 64'hBC010203);
    send_word(32'hAABBCCDD, 1'b1);
    check("second_word", 64'(out_data), 64'hAABBCCDD);
    idle(3);

    // Input gaps.
    drive(1'b1, 8'h12, 1'b1); idle(2);
    drive(1'b1, 8'h34, 1'b1); idle(2);
    drive(1'b1, 8'h56, 1'b1); idle(2);
    drive(1'b1, 8'h78, 1'b1); idle(3);

    // Misplaced COM with words still queued.
    send_word(32'h01020304, 1'b0);
    send_word(32'h05060708, 1'b0);
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, COM, 1'b0);
    check("sync_err_pulse", 64'(sync_err), 64'd1);
    check("sync_unlock", 64'(locked), 64'd0);
    idle(4);
    drive(1'b1, 8'h0A, 1'b1);
    drive(1'b1, 8'h0B, 1'b1);
    drive(1'b1, 8'h0C, 1'b1);
    for (int i = 0; i < 3; i++) send_word(32'hBC203040 + 32'(i), 1'b1);
    idle(3);

    // Backpressure: five words into a four-deep FIFO, then a push coinciding with a pop.
    for (int i = 0; i < 5; i++) send_word(32'h11223300 + 32'(i), 1'b0);
    drive(1'b1, 8'h99, 1'b0);
    drive(1'b1, 8'h98, 1'b0);
    drive(1'b1, 8'h97, 1'b0);
    drive(1'b1, 8'h96, 1'b1);
    check("no_ovf_on_pop", 64'(overflow), 64'd0);
    idle(8);

    // Reset mid-word while locked, with a COM presented on the reset edge.
    drive(1'b1, 8'h21, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    do_reset(1'b1, COM);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 4; i++) send_word(32'hBC0000A0 + 32'(i), 1'b1);
    idle(3);

    // Random traffic.
    rmode = 0;
    pos   = 0;
    for (int i = 0; i < 2500; i++) begin
      if (i % 60 == 0) rmode = int'($urandom_range(0, 2));
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = ($urandom_range(0, 7) == 0);
      endcase
      if ($urandom_range(0, 599) == 0) begin
        do_reset(1'($urandom_range(0, 1)), COM);
      end else begin
        v = ($urandom_range(0, 3) != 0);
        if (pos == 0) d = ($urandom_range(0, 9) != 0) ? COM : 8'($urandom);
        else          d = ($urandom_range(0, 39) == 0) ? COM : 8'($urandom);
        drive(v, d, rdy);
        if (v) pos = (pos + 1) % 4;
      end
    end
    idle(30);
    check("drained", 64'(exp_q.size()), 64'd0);

    // Two-byte words, lock after a single COM-led word.
    do_reset(1'b0, 8'h00);
    in_valid2 = 1'b1;
    in_data2  = COM;
    @(posedge clk_32f);
    #1;
    check("p2_pre_lock", 64'(locked2), 64'd0);
    in_data2 = 8'h07;
    @(posedge clk_32f);
    #1;
    in_valid2 = 1'b0;
    check("p2_locked", 64'(locked2), 64'd1);
    check("p2_valid", 64'(out_valid2), 64'd1);
    check("p2_word", 64'(out_data2), 64'hBC07);
    @(posedge clk_32f);
    #1;
    check("p2_popped", 64'(out_valid2), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phy_byte_word_aligner.md
Name: phy_byte_word_aligner

Overview:
Parametrised successor to the team's 8→32 byte packer. It accepts a byte stream on a single clk_32f domain with valid-qualified input, hunts for the COM symbol, and locks word alignment after a run of COM-led words. Once locked, it packs BYTES_PER_WORD bytes MSB-first into words and delivers them through a small ready/valid output FIFO. It sits between the byte-level receive path and the link/lane logic.

Parameters:
BYTE_W, 8, width of one input symbol
BYTES_PER_WORD, 4, bytes per output word (≥2)
COM_CHAR, 8'hBC, alignment symbol value
LOCK_COUNT, 4, consecutive COM-led words required to lock (≥1)
FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2)

Ports:
clk_32f  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low
in_data  in  BYTE_W  input byte
in_valid  in  1  in_data valid this cycle; no backpressure upstream
out_data  out  BYTE_W*BYTES_PER_WORD  word at FIFO head; first received byte in MSBs
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head word when out_valid&&out_ready
locked  out  1  alignment locked
sync_err  out  1  one-cycle pulse: misplaced COM while LOCKED
overflow  out  1  one-cycle pulse: completed word dropped, FIFO full

Behaviour:
- Reset (reset==0 at a clk_32f edge): state HUNT, lane counter 0, align count 0, FIFO empty. Every output is 0, including out_data (registered head). Reset overrides all concurrent events, including mid-word and mid-transfer.
- Cycles with in_valid==0 change nothing in the packer. FIFO pops still occur.
- Lane counter 0..BYTES_PER_WORD-1 advances on each accepted byte and wraps to 0 when a word completes. Byte at lane k is placed at bits [W-1-k*BYTE_W -: BYTE_W].
- HUNT: non-COM bytes are discarded. A COM byte goes to lane 0, sets lane counter to 1 and moves to ALIGN with align count 0.
- ALIGN: bytes are packed, and words are not pushed.
  - COM at lane k≠0: restarts the word with that COM at lane 0 and clears align count.
  - Word completion, lane 0==COM: align count+1. When it reaches LOCK_COUNT, move to LOCKED; this completing word is the first one pushed.
  - Word completion, lane 0≠COM: impossible by construction; lane 0 is always COM in ALIGN.
  - Non-COM byte at lane 0 (new word start): return to HUNT, byte discarded.
- LOCKED: locked=1 and every completed word is pushed.
  - COM at lane 0 is normal data.
  - COM at lane k≠0: sync_err pulses, the partial word is dropped, locked clears and the state returns to ALIGN. The COM is placed at lane 0 and align count=0.
- Latency: the word is pushed on the edge that accepts its last byte. out_valid/out_data reflect it on the following cycle if the FIFO was empty. locked rises on the same edge as the first push.
- FIFO:
  - Pop on out_valid&&out_ready.
  - Push while full is accepted only if a pop happens in the same cycle.
  - Otherwise the word is dropped and overflow pulses; the packer state is unaffected.
  - Simultaneous push+pop on an empty FIFO is impossible, because out_valid=0.
  - Occupancy never exceeds FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
- Words already queued in the FIFO stay queued after a sync_err. Only reset flushes the FIFO.

Decomposition:
- Shared package phy_pkg holds:
  - COM_CHAR default constant
  - aligner state enum HUNT/ALIGN/LOCKED
  - BYTE_W default
- One natural sub-module, phy_sync_fifo: parametrised width/depth, synchronous active-low reset, push/pop/full/empty, registered head. The aligner FSM and packer stay in the top.

Test Plan:
- Reset mid-word (2 bytes in, while LOCKED) → next cycle locked=0, out_valid=0, out_data=0; a following COM starts HUNT→ALIGN.
- Lock acquisition: bytes 00,11, then 4× {BC,01,02,03}, then {AA,BB,CC,DD} with out_ready=1 → 00,11 discarded; locked rises with the push of the 4th BC010203. out_data=32'hBC010203 then 32'hAABBCCDD, each one cycle after its last byte.
- in_valid gaps: locked stream with in_valid toggling 1,0,0,1… over bytes 12,34,56,78 → single word 32'h12345678, no extra or partial words.
- Misplaced COM: locked, bytes 55,BC → sync_err pulses one cycle and locked=0; word restarts as BC__ in ALIGN. Previously queued words are still delivered.
- Backpressure/overflow: out_ready=0 while 5 words complete (FIFO_DEPTH=4) → 4 words held and overflow pulses once on the 5th. With out_ready=1 on the exact cycle of a push while full, there is no overflow and the word order is preserved.
- Parametrisation: BYTES_PER_WORD=2, LOCK_COUNT=1 → first BC,07 locks immediately and emits 16'hBC07.
